// File: rtl/traffic_pkg.sv
// Shared types and step constants for the traffic-light sequencer and decoder.
package traffic_pkg;

    // Lamp phase as seen by the decoder.
    typedef enum logic [1:0] {
        NS_GREEN  = 2'd0,
        NS_YELLOW = 2'd1,
        EW_GREEN  = 2'd2,
        EW_YELLOW = 2'd3
    } phase_t;

    // Step indices where each phase begins.
    localparam logic [3:0] NS_YELLOW_START = 4'd6;
    localparam logic [3:0] EW_GREEN_START  = 4'd8;
    localparam logic [3:0] EW_YELLOW_START = 4'd14;
    localparam logic [3:0] LAST_STEP       = 4'd15;

    // Map a step index onto its lamp phase.
    function automatic phase_t step_to_phase(input logic [3:0] q);
        phase_t p;
        if (q < NS_YELLOW_START)
            p = NS_GREEN;
        else if (q < EW_GREEN_START)
            p = NS_YELLOW;
        else if (q < EW_YELLOW_START)
            p = EW_GREEN;
        else
            p = EW_YELLOW;
        return p;
    endfunction

endpackage

// File: rtl/traffic_light_seq_tick_gen.sv
// Clock prescaler: emits a one-cycle step event every TICK_DIV running cycles.
// en=0 clears the count; hold freezes it so a released hold resumes mid-count.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic hold,
    output logic step_evt
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_div_cnt;
    logic             w_at_last;

    assign w_at_last = (r_div_cnt == CNT_LAST);

    // Prescaler count: clear when disabled, freeze on hold, else count and wrap.
    // NOTE: reset is sampled on the clock edge (synchronous), and every
    // register update uses <= so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_div_cnt <= '0;
        else if (!en)
            r_div_cnt <= '0;
        else if (!hold)
            r_div_cnt <= w_at_last ? '0 : r_div_cnt + 1'b1;
    end

    assign step_evt = en & ~hold & w_at_last;

endmodule

// File: rtl/traffic_light_seq.sv
// Step sequencer for the two-direction traffic-light decoder. Advances the
// 4-bit step index on each prescaler event, shortening a green to its yellow
// when a pedestrian request is pending and the minimum green has elapsed.
module traffic_light_seq
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MIN_GREEN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       hold,
    input  logic       ped_req,
    output logic [3:0] q,
    output phase_t     phase,
    output logic       tick,
    output logic       ped_ack
);

    localparam logic [2:0] MIN_OFF   = 3'(MIN_GREEN);
    localparam logic [2:0] GREEN_LEN = 3'd6;

    logic [3:0] r_q;
    logic       r_tick;
    logic       r_ped_ack;
    logic       r_ped_pending;

    logic       w_step_evt;
    logic [2:0] w_off;
    logic       w_green;
    logic       w_shortcut;
    logic [3:0] w_next_q;
    logic       w_serve;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .hold     (hold),
        .step_evt (w_step_evt)
    );

    // Next step index and serve decision for the coming step event.
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        w_off      = r_q[2:0];
        w_green    = (w_off < GREEN_LEN);
        w_shortcut = r_ped_pending & w_green & (w_off >= MIN_OFF);
        w_next_q   = (r_q == LAST_STEP) ? 4'd0 : r_q + 4'd1;
        if (w_shortcut)
            w_next_q = r_q[3] ? EW_YELLOW_START : NS_YELLOW_START;
        w_serve    = w_step_evt & r_ped_pending &
                     ((w_next_q == NS_YELLOW_START) || (w_next_q == EW_YELLOW_START));
    end

    // Step register, tick/ack pulses and pedestrian latch (a new request wins over a clear).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q           <= 4'd0;
            r_tick        <= 1'b0;
            r_ped_ack     <= 1'b0;
            r_ped_pending <= 1'b0;
        end else begin
            r_tick    <= w_step_evt;
            r_ped_ack <= w_serve;
            if (w_step_evt)
                r_q <= w_next_q;
            if (ped_req)
                r_ped_pending <= 1'b1;
            else if (w_serve)
                r_ped_pending <= 1'b0;
        end
    end

    assign q       = r_q;
    assign phase   = step_to_phase(r_q);
    assign tick    = r_tick;
    assign ped_ack = r_ped_ack;

endmodule

// File: tb/tb_traffic_light_seq.sv
// Self-checking bench for traffic_light_seq with TICK_DIV=4, MIN_GREEN=2.
module tb_traffic_light_seq;
    import traffic_pkg::*;

    localparam int TD = 4;
    localparam int MG = 2;

    logic       clk = 1'b0;
    logic       rst_n, en, hold, ped_req;
    logic [3:0] q;
    phase_t     phase;
    logic       tick, ped_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    traffic_light_seq #(
        .TICK_DIV  (TD),
        .MIN_GREEN (MG)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .hold    (hold),
        .ped_req (ped_req),
        .q       (q),
        .phase   (phase),
        .tick    (tick),
        .ped_ack (ped_ack)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a cycle counter and the step rules in plain integers.
    int m_cnt, m_q;
    bit m_pend, m_tick, m_ack, m_valid;

    always @(posedge clk) begin
        int nq, base, off;
        bit evt, served;
        if (!rst_n) begin
            m_cnt = 0; m_q = 0; m_pend = 0; m_tick = 0; m_ack = 0;
        end else begin
            evt = en && !hold && (m_cnt == TD - 1);
            if (!en)       m_cnt = 0;
            else if (!hold) m_cnt = (m_cnt + 1) % TD;
            served = 0;
            if (evt) begin
                base = (m_q >= 8) ? 8 : 0;
                off  = m_q - base;
                if (m_pend && off < 6 && off >= MG) nq = base + 6;
                else                                nq = (m_q + 1) % 16;
                served = m_pend && (nq == 6 || nq == 14);
                m_q = nq;
            end
            m_pend = ped_req || (m_pend && !served);
            m_tick = evt;
            m_ack  = served;
        end
        m_valid = 1;
    end

    function automatic int exp_phase(input int mq);
        if (mq < 6)  return 0;
        if (mq < 8)  return 1;
        if (mq < 14) return 2;
        return 3;
    endfunction

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_q",     int'(q),       m_q);
            check("cyc_phase", int'(phase),   exp_phase(m_q));
            check("cyc_tick",  int'(tick),    int'(m_tick));
            check("cyc_ack",   int'(ped_ack), int'(m_ack));
        end
    end

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic wait_state(input string name, input int want_q, input int want_cnt);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            if (m_q == want_q && (want_cnt < 0 || m_cnt == want_cnt)) found = 1;
        end
        check(name, m_q, want_q);
    endtask

    task automatic wait_tick(output int tq, output int tack);
        bit found = 0;
        tq = -1; tack = -1;
        for (int i = 0; i < 10 * TD && !found; i++) begin
            cycle();
            if (tick === 1'b1) begin
                found = 1;
                tq    = int'(q);
                tack  = int'(ped_ack);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int tq, tack, acks;
        int ew_q[5]  = '{7, 8, 9, 10, 14};
        int ew_a[5]  = '{0, 0, 0, 0, 1};
        int nat_q[6] = '{6, 7, 8, 9, 10, 14};
        int nat_a[6] = '{1, 0, 0, 0, 0, 1};

        rst_n = 1'b0; en = 1'b0; hold = 1'b0; ped_req = 1'b0;
        repeat (3) cycle();
        check("reset_q", int'(q), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_ack", int'(ped_ack), 0);
        check("reset_phase", int'(phase), 0);

        // Free run: each q lasts TD cycles, tick on every new q, wrap after 64.
        rst_n = 1'b1; en = 1'b1;
        for (int k = 1; k <= 68; k++) begin
            cycle();
            check("free_q", int'(q), (k / 4) % 16);
            check("free_tick", int'(tick), int'(k % 4 == 0));
        end

        // Hold at q=3 with the prescaler at 2; step arrives 2 cycles after release.
        wait_state("hold_sync", 3, 2);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("hold_q", int'(q), 3);
            check("hold_tick", int'(tick), 0);
        end
        hold = 1'b0;
        cycle();
        check("rel1_q", int'(q), 3);
        check("rel1_tick", int'(tick), 0);
        cycle();
        check("rel2_q", int'(q), 4);
        check("rel2_tick", int'(tick), 1);

        // NS shortcut: pulse at q=1, step to 2, then jump to 6 with ack.
        wait_state("ns_sync", 1, 0);
        ped_req = 1'b1; cycle(); ped_req = 1'b0;
        wait_tick(tq, tack);
        check("ns_step1_q", tq, 2);
        check("ns_step1_ack", tack, 0);
        wait_tick(tq, tack);
        check("ns_step2_q", tq, 6);
        check("ns_step2_ack", tack, 1);

        // Request during NS yellow is served at the EW green off=2 step.
        ped_req = 1'b1; cycle(); ped_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_tick(tq, tack);
            check("ew_q", tq, ew_q[i]);
            check("ew_ack", tack, ew_a[i]);
        end

        // Held request: 5->6 acks but stays pending, then 10->14 acks again.
        wait_state("nat_sync", 5, 0);
        ped_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_tick(tq, tack);
            check("nat_q", tq, nat_q[i]);
            check("nat_ack", tack, nat_a[i]);
        end
        ped_req = 1'b0;

        // en=0 freezes q and suppresses ticks.
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("dis_q", int'(q), 14);
            check("dis_tick", int'(tick), 0);
        end
        en = 1'b1;

        // Reset mid-run with a pending request at q=12.
        wait_state("rst_sync", 12, 0);
        ped_req = 1'b1; cycle(); ped_req = 1'b0;
        rst_n = 1'b0;
        cycle();
        check("midrst_q", int'(q), 0);
        check("midrst_tick", int'(tick), 0);
        check("midrst_ack", int'(ped_ack), 0);
        rst_n = 1'b1;
        acks = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (ped_ack === 1'b1) acks++;
        end
        check("postrst_acks", acks, 0);
        check("postrst_q", int'(q), 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
